// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and the load/store
// unit (LS). Only one transaction is in flight at a time. The response is
// routed back to whichever requester owns the in-flight transaction.
//
// Flow: IDLE (grant + latch) -> REQ (hold request until mem_req_ready)
//       -> WAIT (route mem_resp_valid to owner) -> IDLE
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   if_req_valid/ready    fetch request handshake; if_addr is the fetch address
//   if_resp_valid/rdata   fetch data; one-cycle pulse; rdata is 0 otherwise
//   ls_req_valid/ready    load/store request handshake
//   ls_addr/wen/wdata/wstrb  load/store request fields (wen=1 means store)
//   ls_resp_valid/rdata   load data or store acknowledge; one-cycle pulse
//   mem_req_valid/ready   request handshake toward the memory bridge
//   mem_addr/wen/wdata/wstrb  latched request fields
//   mem_resp_valid/rdata  memory response (one per accepted request)
//   busy                  high whenever the arbiter is not IDLE
//
// Optional build macro: MEM_ARB_STARVE_GUARD_EN
//   When defined, a saturating counter tracks LS grants made while IF was
//   waiting. Once the counter reaches STARVE_LIMIT, IF wins the next IDLE
//   arbitration even if LS is requesting. When the macro is undefined, LS
//   has strict priority.

module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STRB_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;   // 0 = IF owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic grant_ls;
  logic grant_if;
  logic starve_hit;
  logic resp_fire;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

  // When starve_hit is set, an LS grant can only happen with IF idle,
  // so the counter never needs to step past STARVE_LIMIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_ls && if_req_valid && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Arbitration happens only in IDLE. LS has priority unless the starvation
  // guard forces a turn for a waiting IF. Reset suppresses any accept.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (ls_req_valid && !(starve_hit && if_req_valid)) begin
        grant_ls = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ls) begin
          state_d    = S_REQ;
          owner_ls_d = 1'b1;
          addr_d     = ls_addr;
          wen_d      = ls_wen;
          wdata_d    = ls_wdata;
          wstrb_d    = ls_wstrb;
        end else if (grant_if) begin
          // Fetches are always reads: no write data or strobes escape.
          state_d    = S_REQ;
          owner_ls_d = 1'b0;
          addr_d     = if_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wstrb_d    = '0;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // A response outside WAIT is a protocol error and is dropped silently.
  // Reset also kills a response arriving in the same cycle.
  assign resp_fire = (state_q == S_WAIT) && mem_resp_valid && !rst;

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;

  // The memory handshake is withdrawn in the reset cycle itself so the
  // bridge never sees a request that the arbiter is about to forget.
  assign mem_req_valid = (state_q == S_REQ) && !rst;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

  assign if_resp_valid = resp_fire && !owner_ls_q;
  assign ls_resp_valid = resp_fire && owner_ls_q;
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge. The reference model works at transaction level: it picks
// the winner from the arbitration rule and predicts the mem_* fields and the
// response routing, cycle by cycle, from the stall and delay chosen for each
// transaction.

module tb_mem_port_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int SW    = 8;
  localparam int LIMIT = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_resp_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready;
  logic [AW-1:0] ls_addr;
  logic          ls_wen;
  logic [DW-1:0] ls_wdata;
  logic [SW-1:0] ls_wstrb;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;
  int model_starve = 0;   // LS grants while IF waited, saturating at LIMIT

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    if_req_valid   = 1'b0;
    if_addr        = '0;
    ls_req_valid   = 1'b0;
    ls_addr        = '0;
    ls_wen         = 1'b0;
    ls_wdata       = '0;
    ls_wstrb       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic rand_ls();
    ls_req_valid = 1'b1;
    ls_addr      = rand64();
    ls_wen       = 1'($urandom_range(0, 1));
    ls_wdata     = rand64();
    ls_wstrb     = 8'($urandom);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_starve = 0;
  endtask

  // Arbitration rule: LS wins unless the guard is active, IF is waiting
  // and LIMIT LS grants have already gone by while IF waited.
  function automatic bit model_pick_ls();
    if (!ls_req_valid) return 1'b0;
    if (GUARD_EN && if_req_valid && model_starve >= LIMIT) return 1'b0;
    return 1'b1;
  endfunction

  // One full transaction starting in IDLE with requests already driven.
  // Memory stalls 'stall' cycles before accepting and answers 'delay'
  // cycles after the accept cycle. Returns the observed grant.
  task automatic run_txn(input int stall, input int delay, input logic [63:0] rd,
                         output bit got_ls);
    bit            exp_ls, ifv, last;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed, eif_rd, els_rd;
    logic [SW-1:0] es;
    exp_ls = model_pick_ls();
    ifv    = if_req_valid;
    ea     = exp_ls ? ls_addr : if_addr;
    ew     = exp_ls ? ls_wen : 1'b0;
    ed     = ls_wdata;
    es     = exp_ls ? ls_wstrb : '0;
    txn_no++;
    $display("txn %0d: owner=%s addr=%h wen=%0b stall=%0d delay=%0d rdata=%h",
             txn_no, exp_ls ? "LS" : "IF", ea, ew, stall, delay, rd);

    @(negedge clk);
    checks++;
    if ({ls_req_ready, if_req_ready} !== {exp_ls, ~exp_ls}) begin
      errors++;
      $display("FAIL grant: got ls_rdy=%0b if_rdy=%0b, want ls_rdy=%0b if_rdy=%0b",
               ls_req_ready, if_req_ready, exp_ls, ~exp_ls);
    end
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_phase: got busy=%0b mem_req_valid=%0b, want 0 0", busy, mem_req_valid);
    end
    got_ls = ls_req_ready;
    if (exp_ls) begin
      if (ifv && model_starve < LIMIT) model_starve++;
    end else begin
      model_starve = 0;
    end

    @(posedge clk); #1;
    if (exp_ls) ls_req_valid = 1'b0;
    else        if_req_valid = 1'b0;

    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_addr, mem_wen, mem_wstrb} !== {1'b1, ea, ew, es}) begin
        errors++;
        $display("FAIL mem_req: got v=%0b addr=%h wen=%0b strb=%h, want v=1 addr=%h wen=%0b strb=%h",
                 mem_req_valid, mem_addr, mem_wen, mem_wstrb, ea, ew, es);
      end
      if (exp_ls) begin
        checks++;
        if (mem_wdata !== ed) begin
          errors++;
          $display("FAIL mem_wdata: got %h, want %h", mem_wdata, ed);
        end
      end
      checks++;
      if ({if_req_ready, ls_req_ready, busy, if_resp_valid, ls_resp_valid} !== 5'b00100) begin
        errors++;
        $display("FAIL req_phase: got if_rdy=%0b ls_rdy=%0b busy=%0b if_rv=%0b ls_rv=%0b, want 0 0 1 0 0",
                 if_req_ready, ls_req_ready, busy, if_resp_valid, ls_resp_valid);
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;

    for (int d = 0; d <= delay; d++) begin
      last           = (d == delay);
      mem_resp_valid = last;
      mem_rdata      = last ? rd : rand64();
      eif_rd         = (last && !exp_ls) ? rd : '0;
      els_rd         = (last && exp_ls) ? rd : '0;
      @(negedge clk);
      checks++;
      if ({mem_req_valid, if_req_ready, ls_req_ready, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL wait_phase: got mem_v=%0b if_rdy=%0b ls_rdy=%0b busy=%0b, want 0 0 0 1",
                 mem_req_valid, if_req_ready, ls_req_ready, busy);
      end
      checks++;
      if ({if_resp_valid, ls_resp_valid} !== {last & ~exp_ls, last & exp_ls}) begin
        errors++;
        $display("FAIL resp_valid: got if_rv=%0b ls_rv=%0b, want %0b %0b",
                 if_resp_valid, ls_resp_valid, last & ~exp_ls, last & exp_ls);
      end
      checks++;
      if ({if_rdata, ls_rdata} !== {eif_rd, els_rd}) begin
        errors++;
        $display("FAIL resp_data: got if=%h ls=%h, want if=%h ls=%h",
                 if_rdata, ls_rdata, eif_rd, els_rd);
      end
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, mem_wen, busy} !== 7'b0) begin
      errors++;
      $display("FAIL %s ctrl: got if_rdy=%0b ls_rdy=%0b if_rv=%0b ls_rv=%0b mem_v=%0b wen=%0b busy=%0b, want all 0",
               tag, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, mem_wen, busy);
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL %s data: got addr=%h wdata=%h strb=%h if_rd=%h ls_rd=%h, want all 0",
               tag, mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    bit got;
    if_req_valid = 1'b1;
    if_addr      = 64'h0000_0000_8000_0000;
    run_txn(0, 0, 64'h0000_0013_0000_0093, got);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("FAIL single_fetch_owner: got ls=%0b, want ls=0", got);
    end
  endtask

  task automatic test_store();
    bit got;
    ls_req_valid = 1'b1;
    ls_wen       = 1'b1;
    ls_addr      = 64'h0000_0000_8000_1000;
    ls_wdata     = 64'h0000_0000_DEAD_BEEF;
    ls_wstrb     = 8'h0F;
    run_txn(0, 0, rand64(), got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL store_owner: got ls=%0b, want ls=1", got);
    end
    // The acknowledge is a single pulse.
    @(negedge clk);
    checks++;
    if (ls_resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL store_single_pulse: got ls_rv=%0b busy=%0b, want 0 0", ls_resp_valid, busy);
    end
    @(posedge clk); #1;
    ls_wen = 1'b0;
  endtask

  task automatic test_contention();
    bit got;
    bit exp_seq [3];
    apply_reset();
    exp_seq[0] = 1'b1;
    exp_seq[1] = 1'b1;
    exp_seq[2] = GUARD_EN ? 1'b0 : 1'b1;
    if_req_valid = 1'b1;
    if_addr      = rand64();
    for (int k = 0; k < 3; k++) begin
      if (!ls_req_valid) rand_ls();
      run_txn(0, $urandom_range(0, 1), rand64(), got);
      checks++;
      if (got !== exp_seq[k]) begin
        errors++;
        $display("FAIL contention_grant%0d: got ls=%0b, want ls=%0b", k, got, exp_seq[k]);
      end
    end
    // Without the guard IF is still waiting and wins once LS stops asking;
    // with it, the pending LS request goes next.
    run_txn(0, 0, rand64(), got);
    checks++;
    if (got !== GUARD_EN) begin
      errors++;
      $display("FAIL contention_tail: got ls=%0b, want ls=%0b", got, GUARD_EN);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    rand_ls();
    ls_wen = 1'b0;
    if_req_valid = 1'b1;
    if_addr      = rand64();
    run_txn(5, 1, rand64(), got);
    if_req_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    idle_inputs();
    if_req_valid = 1'b1;
    if_addr      = rand64();
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_accept: got if_rdy=%0b, want 1", if_req_ready);
    end
    @(posedge clk); #1;
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_req: got mem_v=%0b, want 1", mem_req_valid);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_during: got if_rv=%0b ls_rv=%0b, want 0 0", if_resp_valid, ls_resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_starve = 0;
    @(negedge clk);
    check_all_zero("rstwait_after");
    @(posedge clk); #1;
    mem_resp_valid = 1'b1;
    mem_rdata      = rand64();
    @(negedge clk);
    checks++;
    if ({if_resp_valid, ls_resp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rstwait_stray: got if_rv=%0b ls_rv=%0b busy=%0b, want 0 0 0",
               if_resp_valid, ls_resp_valid, busy);
    end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic test_stray();
    bit got;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = rand64();
      @(negedge clk);
      checks++;
      if ({if_resp_valid, ls_resp_valid, busy, mem_req_valid} !== 4'b0000) begin
        errors++;
        $display("FAIL stray_idle: got if_rv=%0b ls_rv=%0b busy=%0b mem_v=%0b, want 0 0 0 0",
                 if_resp_valid, ls_resp_valid, busy, mem_req_valid);
      end
      checks++;
      if ({if_rdata, ls_rdata} !== '0) begin
        errors++;
        $display("FAIL stray_rdata: got if=%h ls=%h, want 0 0", if_rdata, ls_rdata);
      end
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    // Arbiter still in IDLE: a normal fetch goes through unaffected.
    if_req_valid = 1'b1;
    if_addr      = rand64();
    run_txn(0, 0, rand64(), got);
  endtask

  task automatic test_random();
    bit got;
    for (int n = 0; n < 40; n++) begin
      if (!if_req_valid && $urandom_range(0, 1) == 1) begin
        if_req_valid = 1'b1;
        if_addr      = rand64();
      end
      if (!ls_req_valid && $urandom_range(0, 2) != 0) rand_ls();
      if (!if_req_valid && !ls_req_valid) begin
        if_req_valid = 1'b1;
        if_addr      = rand64();
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), rand64(), got);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_backpressure();
    test_reset_in_wait();
    test_stray();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
